// File: rtl/alu_seq.sv
// Registered MIPS-style ALU with valid/ready handshake and an iterative shift-add multiplier.
// Single-cycle ops land in the output register on the accept edge; MUL takes WIDTH extra edges.
module alu_seq #(
    parameter int WIDTH   = 16,
    parameter int SHAMT_W = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic [WIDTH-1:0] result_hi,
    output logic             zero,
    output logic             overflow,
    output logic             carry,
    output logic             illegal
);

    localparam logic [3:0] OP_AND = 4'b0000;
    localparam logic [3:0] OP_OR  = 4'b0001;
    localparam logic [3:0] OP_ADD = 4'b0010;
    localparam logic [3:0] OP_SUB = 4'b0110;
    localparam logic [3:0] OP_SLT = 4'b0111;
    localparam logic [3:0] OP_NOR = 4'b1100;
    localparam logic [3:0] OP_SLL = 4'b1000;
    localparam logic [3:0] OP_SRL = 4'b1001;
    localparam logic [3:0] OP_SRA = 4'b1011;
    localparam logic [3:0] OP_MUL = 4'b1010;

    typedef enum logic [1:0] {S_IDLE, S_MUL, S_HOLD} state_t;

    typedef struct packed {
        logic [WIDTH-1:0] res;
        logic             ov;
        logic             cy;
        logic             ill;
    } alu_rsp_t;

    state_t             state;
    alu_rsp_t           rsp;
    logic               sub_op;
    logic [WIDTH-1:0]   b_eff;
    logic [WIDTH:0]     sum_full;
    logic [WIDTH-1:0]   sum;
    logic               add_ov;
    logic [SHAMT_W-1:0] shamt;
    logic               accept;

    logic [2*WIDTH-1:0] mcand;
    logic [2*WIDTH-1:0] acc;
    logic [2*WIDTH-1:0] acc_nxt;
    logic [WIDTH-1:0]   mplier;
    logic [SHAMT_W-1:0] cnt;

    assign in_ready = (state == S_IDLE) | ((state == S_HOLD) & out_ready);
    assign accept   = in_valid & in_ready;

    // SLT shares the subtractor so its sign test sees the true overflow
    assign sub_op   = (op == OP_SUB) | (op == OP_SLT);
    assign b_eff    = sub_op ? ~b : b;
    assign sum_full = {1'b0, a} + {1'b0, b_eff} + {{WIDTH{1'b0}}, sub_op};
    assign sum      = sum_full[WIDTH-1:0];
    assign add_ov   = (a[WIDTH-1] == b_eff[WIDTH-1]) & (sum[WIDTH-1] != a[WIDTH-1]);
    assign shamt    = b[SHAMT_W-1:0];
    assign acc_nxt  = acc + (mplier[0] ? mcand : '0);

    always_comb begin
        rsp = '0;
        case (op)
            OP_AND: rsp.res = a & b;
            OP_OR:  rsp.res = a | b;
            OP_ADD: begin
                rsp.res = sum;
                rsp.ov  = add_ov;
                rsp.cy  = sum_full[WIDTH];
            end
            OP_SUB: begin
                rsp.res = sum;
                rsp.ov  = add_ov;
                rsp.cy  = sum_full[WIDTH];
            end
            OP_SLT: rsp.res = {{(WIDTH-1){1'b0}}, sum[WIDTH-1] ^ add_ov};
            OP_NOR: rsp.res = ~(a | b);
            OP_SLL: rsp.res = a << shamt;
            OP_SRL: rsp.res = a >> shamt;
            OP_SRA: rsp.res = $unsigned($signed(a) >>> shamt);
            OP_MUL: rsp.res = '0;
            default: rsp.ill = 1'b1;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            out_valid <= 1'b0;
            result    <= '0;
            result_hi <= '0;
            zero      <= 1'b0;
            overflow  <= 1'b0;
            carry     <= 1'b0;
            illegal   <= 1'b0;
            mcand     <= '0;
            acc       <= '0;
            mplier    <= '0;
            cnt       <= '0;
        end else begin
            case (state)
                S_MUL: begin
                    acc    <= acc_nxt;
                    mcand  <= {mcand[2*WIDTH-2:0], 1'b0};
                    mplier <= {1'b0, mplier[WIDTH-1:1]};
                    cnt    <= cnt + 1'b1;
                    if (cnt == SHAMT_W'(WIDTH-1)) begin
                        state     <= S_HOLD;
                        out_valid <= 1'b1;
                        result    <= acc_nxt[WIDTH-1:0];
                        result_hi <= acc_nxt[2*WIDTH-1:WIDTH];
                        zero      <= (acc_nxt[WIDTH-1:0] == '0);
                        overflow  <= 1'b0;
                        carry     <= 1'b0;
                        illegal   <= 1'b0;
                    end
                end
                default: begin
                    if (accept) begin
                        if (op == OP_MUL) begin
                            // output register keeps the old result until the product is loaded
                            state     <= S_MUL;
                            out_valid <= 1'b0;
                            cnt       <= '0;
                            acc       <= '0;
                            mcand     <= {{WIDTH{1'b0}}, a};
                            mplier    <= b;
                        end else begin
                            state     <= S_HOLD;
                            out_valid <= 1'b1;
                            result    <= rsp.res;
                            result_hi <= '0;
                            zero      <= (rsp.res == '0) & ~rsp.ill;
                            overflow  <= rsp.ov;
                            carry     <= rsp.cy;
                            illegal   <= rsp.ill;
                        end
                    end else if ((state == S_HOLD) && out_ready) begin
                        state     <= S_IDLE;
                        out_valid <= 1'b0;
                    end
                end
            endcase
        end
    end

endmodule
